// File: rtl/sc_onehot_pkg.sv
// Shared types and width helpers for the one-hot lane encoder.
// Consumers: sc_onehot_lane_encoder (top) and its testbench.
package sc_onehot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to address a lane; never narrower than one bit.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Bits needed for a counter that is loaded with hold_cycles-1.
    function automatic int hold_cnt_w(input int hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage

// File: rtl/sc_rise_edge.sv
// Rising-edge detector: one history flop, pulse = level & ~previous level.
// History clears on reset so a level held through reset yields one pulse afterwards.
module sc_rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/sc_onehot_lane_encoder.sv
// Registered one-hot lane word driven by left/right/load button edges with a hold-off window.
// Optional build macro SC_ONEHOT_LANE_WRAP_EN: moves past the outer lanes wrap instead of saturating.
module sc_onehot_lane_encoder
    import sc_onehot_pkg::*;
#(
    parameter int DATAWIDTH   = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int RESET_LANE  = 0
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_InHigh,
    input  logic                         left_InHigh,
    input  logic                         right_InHigh,
    input  logic                         load_InHigh,
    input  logic [$clog2(DATAWIDTH)-1:0] index_In,
    output logic [DATAWIDTH-1:0]         data_out,
    output logic                         load_out,
    output logic                         busy_out
);

    localparam int CW = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [DATAWIDTH-1:0] ONE_WORD = {{(DATAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATAWIDTH-1:0] RESET_WORD = ONE_WORD << RESET_LANE;

`ifdef SC_ONEHOT_LANE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic left_rise;
    logic right_rise;
    logic load_rise;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        hold_cnt;
    logic [DATAWIDTH-1:0] word_nxt;
    logic                 accept;
    logic                 load_ok;
    logic                 move_left;
    logic                 move_right;
    logic                 left_ok;
    logic                 right_ok;

    sc_rise_edge u_left_edge (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .level (left_InHigh),
        .rise  (left_rise)
    );

    sc_rise_edge u_right_edge (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .level (right_InHigh),
        .rise  (right_rise)
    );

    sc_rise_edge u_load_edge (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .level (load_InHigh),
        .rise  (load_rise)
    );

    // Out-of-range load targets are dropped; opposing move edges cancel each other.
    assign load_ok    = load_rise && (32'(index_In) < 32'(DATAWIDTH));
    assign move_left  = left_rise && !right_rise;
    assign move_right = right_rise && !left_rise;
    assign left_ok    = WRAP_EN || !data_out[DATAWIDTH-1];
    assign right_ok   = WRAP_EN || !data_out[0];

    // Rotation equals a plain shift away from the edges, so one form serves both modes.
    always_comb begin
        word_nxt = data_out;
        accept   = 1'b0;
        if (state == IDLE) begin
            if (load_rise) begin
                if (load_ok) begin
                    accept   = 1'b1;
                    word_nxt = ONE_WORD << index_In;
                end
            end else if (move_left && left_ok) begin
                accept   = 1'b1;
                word_nxt = {data_out[DATAWIDTH-2:0], data_out[DATAWIDTH-1]};
            end else if (move_right && right_ok) begin
                accept   = 1'b1;
                word_nxt = {data_out[0], data_out[DATAWIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state == HOLD);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            hold_cnt <= '0;
            data_out <= RESET_WORD;
            load_out <= 1'b0;
        end else begin
            load_out <= accept;
            data_out <= word_nxt;
            if (accept) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sc_onehot_lane_encoder.sv
// Bench for sc_onehot_lane_encoder: a 4-lane and a 3-lane instance against a lane-number model.
// Honours SC_ONEHOT_LANE_WRAP_EN when the same macro is defined for the build.
module tb_sc_onehot_lane_encoder;

`ifdef SC_ONEHOT_LANE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int HOLD = 4;

    logic       clk;
    logic       rst0, l0, r0, ld0;
    logic [1:0] idx0;
    logic [3:0] d0;
    logic       lo0, b0;
    logic       rst1, l1, r1, ld1;
    logic [1:0] idx1;
    logic [2:0] d1;
    logic       lo1, b1;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    // Model state: current lane number, remaining busy cycles, strobe, previous input levels.
    int lane [2];
    int bl   [2];
    bit stb  [2];
    bit pl   [2];
    bit pr   [2];
    bit pd   [2];

    sc_onehot_lane_encoder #(.DATAWIDTH(4), .HOLD_CYCLES(HOLD), .RESET_LANE(0)) dut0 (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst0),
        .left_InHigh  (l0),
        .right_InHigh (r0),
        .load_InHigh  (ld0),
        .index_In     (idx0),
        .data_out     (d0),
        .load_out     (lo0),
        .busy_out     (b0)
    );

    sc_onehot_lane_encoder #(.DATAWIDTH(3), .HOLD_CYCLES(HOLD), .RESET_LANE(0)) dut1 (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst1),
        .left_InHigh  (l1),
        .right_InHigh (r1),
        .load_InHigh  (ld1),
        .index_In     (idx1),
        .data_out     (d1),
        .load_out     (lo1),
        .busy_out     (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input int d, input bit rst, input bit l, input bit r,
                              input bit ld, input int idx);
        bit le, re, de;
        int w;
        w = (d == 0) ? 4 : 3;
        if (rst) begin
            lane[d] = 0; bl[d] = 0; stb[d] = 1'b0;
            pl[d] = 1'b0; pr[d] = 1'b0; pd[d] = 1'b0;
            return;
        end
        le = l && !pl[d];
        re = r && !pr[d];
        de = ld && !pd[d];
        pl[d] = l; pr[d] = r; pd[d] = ld;
        stb[d] = 1'b0;
        if (bl[d] > 0) begin
            bl[d] = bl[d] - 1;
            return;
        end
        if (de) begin
            if (idx < w) begin lane[d] = idx; stb[d] = 1'b1; end
        end else if (le && !re) begin
            if (lane[d] < w - 1) begin lane[d] = lane[d] + 1; stb[d] = 1'b1; end
            else if (WRAP) begin lane[d] = 0; stb[d] = 1'b1; end
        end else if (re && !le) begin
            if (lane[d] > 0) begin lane[d] = lane[d] - 1; stb[d] = 1'b1; end
            else if (WRAP) begin lane[d] = w - 1; stb[d] = 1'b1; end
        end
        if (stb[d]) bl[d] = HOLD;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst0, l0, r0, ld0, int'(idx0));
        model_step(1, rst1, l1, r1, ld1, int'(idx1));
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [3:0] w0();
        return 4'b0001 << lane[0];
    endfunction

    function automatic logic [2:0] w1();
        return 3'b001 << lane[1];
    endfunction

    task automatic test_reset();
        rst0 = 1; rst1 = 1; l0 = 0; r0 = 0; ld0 = 0; l1 = 0; r1 = 0; ld1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin rst0 = 0; rst1 = 0; end
            tick();
            vectors++;
            if ({d0, lo0, b0} !== {4'b0001, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset4 cyc=%0d got d=%b ld=%b busy=%b want d=0001 ld=0 busy=0", cyc, d0, lo0, b0);
            end
            vectors++;
            if ({d1, lo1, b1} !== {3'b001, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset3 cyc=%0d got d=%b ld=%b busy=%b want d=001 ld=0 busy=0", cyc, d1, lo1, b1);
            end
        end
        // Left held through reset must still register once after release.
        rst0 = 1; l0 = 1;
        tick();
        rst0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({d0, lo0, b0} !== {w0(), stb[0], bl[0] > 0}) begin
                fails++;
                $display("FAIL held_reset cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d0, lo0, b0, w0(), stb[0], bl[0] > 0);
            end
        end
        vectors++;
        if (d0 !== 4'b0010) begin
            fails++;
            $display("FAIL held_reset_final got d=%b want d=0010", d0);
        end
        l0 = 0;
    endtask

    task automatic test_left_holdoff();
        bit pat [12] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        rst0 = 1; tick(); rst0 = 0;
        for (int i = 0; i < 12; i++) begin
            l0 = pat[i];
            tick();
            vectors++;
            if ({d0, lo0, b0} !== {w0(), stb[0], bl[0] > 0}) begin
                fails++;
                $display("FAIL left_holdoff cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d0, lo0, b0, w0(), stb[0], bl[0] > 0);
            end
        end
        vectors++;
        if (d0 !== 4'b0100) begin
            fails++;
            $display("FAIL left_holdoff_final got d=%b want d=0100", d0);
        end
    endtask

    task automatic test_held_level();
        int pulses = 0;
        rst0 = 1; tick(); rst0 = 0;
        l0 = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lo0) pulses++;
            vectors++;
            if ({d0, lo0, b0} !== {w0(), stb[0], bl[0] > 0}) begin
                fails++;
                $display("FAIL held_level cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d0, lo0, b0, w0(), stb[0], bl[0] > 0);
            end
        end
        l0 = 0;
        vectors++;
        if (pulses !== 1 || d0 !== 4'b0010) begin
            fails++;
            $display("FAIL held_level_count got pulses=%0d d=%b want pulses=1 d=0010", pulses, d0);
        end
    endtask

    task automatic test_edge_lane();
        rst0 = 1; tick(); rst0 = 0;
        idx0 = 2'd3; ld0 = 1; tick(); ld0 = 0;
        for (int i = 0; i < HOLD; i++) tick();
        vectors++;
        if ({d0, b0} !== {4'b1000, 1'b0}) begin
            fails++;
            $display("FAIL edge_setup got d=%b busy=%b want d=1000 busy=0", d0, b0);
        end
        l0 = 1; tick(); l0 = 0;
        vectors++;
        if ({d0, lo0, b0} !== (WRAP ? {4'b0001, 1'b1, 1'b1} : {4'b1000, 1'b0, 1'b0})) begin
            fails++;
            $display("FAIL edge_left cyc=%0d got d=%b ld=%b busy=%b wrap=%0d", cyc, d0, lo0, b0, WRAP);
        end
        for (int i = 0; i < HOLD + 1; i++) begin
            tick();
            vectors++;
            if ({d0, lo0, b0} !== {w0(), stb[0], bl[0] > 0}) begin
                fails++;
                $display("FAIL edge_after cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d0, lo0, b0, w0(), stb[0], bl[0] > 0);
            end
        end
    endtask

    task automatic test_priority();
        rst0 = 1; tick(); rst0 = 0;
        l0 = 1; tick(); l0 = 0;
        for (int i = 0; i < HOLD; i++) tick();
        idx0 = 2'd2; ld0 = 1; r0 = 1; tick(); ld0 = 0; r0 = 0;
        vectors++;
        if ({d0, lo0} !== {4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL load_beats_right got d=%b ld=%b want d=0100 ld=1", d0, lo0);
        end
        for (int i = 0; i < HOLD; i++) tick();
        l0 = 1; r0 = 1; tick(); l0 = 0; r0 = 0;
        vectors++;
        if ({d0, lo0, b0} !== {4'b0100, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL left_right_cancel got d=%b ld=%b busy=%b want d=0100 ld=0 busy=0", d0, lo0, b0);
        end
    endtask

    task automatic test_width3();
        rst1 = 1; tick(); rst1 = 0;
        idx1 = 2'd3; ld1 = 1; tick(); ld1 = 0;
        vectors++;
        if ({d1, lo1, b1} !== {3'b001, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL w3_bad_index got d=%b ld=%b busy=%b want d=001 ld=0 busy=0", d1, lo1, b1);
        end
        idx1 = 2'd2; ld1 = 1; tick(); ld1 = 0;
        tick();
        rst1 = 1; tick(); rst1 = 0;
        vectors++;
        if ({d1, lo1, b1} !== {3'b001, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL w3_reset_in_hold got d=%b ld=%b busy=%b want d=001 ld=0 busy=0", d1, lo1, b1);
        end
        tick();
        l1 = 1; tick(); l1 = 0;
        vectors++;
        if ({d1, lo1, b1} !== {3'b010, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL w3_after_reset got d=%b ld=%b busy=%b want d=010 ld=1 busy=1", d1, lo1, b1);
        end
    endtask

    task automatic test_random();
        rst0 = 1; rst1 = 1; tick(); rst0 = 0; rst1 = 0;
        for (int i = 0; i < 1500; i++) begin
            rst0 = ($urandom_range(0, 99) == 0);
            rst1 = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) l0  = ~l0;
            if ($urandom_range(0, 3) == 0) r0  = ~r0;
            if ($urandom_range(0, 5) == 0) ld0 = ~ld0;
            if ($urandom_range(0, 3) == 0) l1  = ~l1;
            if ($urandom_range(0, 3) == 0) r1  = ~r1;
            if ($urandom_range(0, 5) == 0) ld1 = ~ld1;
            idx0 = 2'($urandom_range(0, 3));
            idx1 = 2'($urandom_range(0, 3));
            tick();
            vectors++;
            if ({d0, lo0, b0} !== {w0(), stb[0], bl[0] > 0}) begin
                fails++;
                $display("FAIL rand4 cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d0, lo0, b0, w0(), stb[0], bl[0] > 0);
            end
            vectors++;
            if ({d1, lo1, b1} !== {w1(), stb[1], bl[1] > 0}) begin
                fails++;
                $display("FAIL rand3 cyc=%0d got d=%b ld=%b busy=%b want d=%b ld=%b busy=%b",
                         cyc, d1, lo1, b1, w1(), stb[1], bl[1] > 0);
            end
        end
        rst0 = 0; rst1 = 0; l0 = 0; r0 = 0; ld0 = 0; l1 = 0; r1 = 0; ld1 = 0;
    endtask

    initial begin
        rst0 = 1; l0 = 0; r0 = 0; ld0 = 0; idx0 = '0;
        rst1 = 1; l1 = 0; r1 = 0; ld1 = 0; idx1 = '0;
        @(negedge clk);
        test_reset();
        test_left_holdoff();
        test_held_level();
        test_edge_lane();
        test_priority();
        test_width3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
